button_counter_updown: RTL
==========================

# button_counter_updown

Parametrised up/down button counter. It replaces the single-button increment counter on the board-level demo path. It takes two raw active-low push buttons (increment, decrement), synchronises and debounces them, and applies auto-repeat while a button is held. It drives a WIDTH-bit count with wrap or saturate arithmetic, a one-cycle step strobe, and limit flags for LEDs or downstream logic.

## Interface
- WIDTH, 4: count width in bits (≥1).
- DEBOUNCE_CYCLES, 5000000: number of consecutive stable-pressed cycles required before the first step. Also the number of stable-released cycles required before re-arming (≥1).
- REPEAT_EN, 1: 1 = auto-repeat while held; 0 = one step per press.
- REPEAT_DELAY, 25000000: cycles held in HOLD before the first repeat (≥1).
- REPEAT_PERIOD, 5000000: cycles held in HOLD between subsequent repeats (≥1).
- WRAP, 0: 1 = modulo 2^WIDTH; 0 = saturate at 0 and 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- inc_btn  input  1  raw increment button, active-low, asynchronous to clk.
- dec_btn  input  1  raw decrement button, active-low, asynchronous to clk.
- count  output  WIDTH  current count value.
- step  output  1  one-cycle pulse in the cycle after count changes.
- step_dir  output  1  direction of the last step: 1 = up, 0 = down.
- at_min  output  1  high when count == 0.
- at_max  output  1  high when count == 2^WIDTH-1.

## Operation
- Each button passes through a 2-flop synchroniser, reset to 1 (released). pressed = ~synchronised.
- One shared down-counting timer, sized internally for the largest of the three cycle parameters. A dir register latches the active button.
- States: IDLE, DEBOUNCE, STEP, HOLD, RELEASE.
  - IDLE: if exactly one button is pressed, latch dir, load timer DEBOUNCE_CYCLES-1, go to DEBOUNCE. If both or neither is pressed, stay.
  - DEBOUNCE: if the latched button is released or the other button is pressed, go to IDLE. Else if timer==0, go to STEP. Else decrement the timer.
  - STEP (one cycle): apply the step to count. Load timer REPEAT_DELAY-1 on the first step of a press, REPEAT_PERIOD-1 on repeats. Go to HOLD.
  - HOLD: if the latched button is released, load DEBOUNCE_CYCLES-1 and go to RELEASE. Else if REPEAT_EN and timer==0, go to STEP (repeat). Else decrement the timer (saturate at 0 when REPEAT_EN=0). The other button is ignored.
  - RELEASE: if the latched button is pressed again, reload DEBOUNCE_CYCLES-1 and stay. Else if timer==0, go to IDLE. Else decrement. The other button is ignored.
- Step arithmetic:
  - Up adds 1; down subtracts 1.
  - WRAP=1: 2^WIDTH-1 +1 → 0 and 0 −1 → 2^WIDTH-1. step always pulses.
  - WRAP=0: at a limit, count is held and no step pulse occurs. The FSM sequence and timing are unchanged.
- step_dir updates only when step pulses.
- at_min and at_max are combinational from count.
- Unused state encodings return to IDLE.
- Reset (any time, including mid-press or mid-repeat) forces the following:
  - state IDLE, timer 0, synchronisers 1.
  - count 0, step 0, step_dir 0.
  - at_min 1, at_max 0.

## Timing
- Let edge 0 be the first rising edge that samples the pin low.
- The synchronised pressed signal is visible after edge 1. The FSM enters DEBOUNCE at edge 2 and STEP at edge 2+DEBOUNCE_CYCLES.
- count changes at edge 3+DEBOUNCE_CYCLES, and step is high for exactly that following cycle.
- Auto-repeat updates occur REPEAT_DELAY+1 cycles after the first step, then every REPEAT_PERIOD+1 cycles while the button stays held.
- A pressed pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no step.
- After release, a new press cannot step earlier than DEBOUNCE_CYCLES cycles (release filter) plus the full debounce latency.
- Maximum of one step per press when REPEAT_EN=0. Never more than one count change per cycle.

## Test plan
Parameters: WIDTH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Clean press: inc low from edge 0 for 12 cycles, then high → count 0→1 at edge 7, step high one cycle, step_dir=1, no further change.
- Bounce rejection: inc low 3 cycles, high 2, low 3, high → count stays 0 and step never asserts.
- Auto-repeat (REPEAT_EN=1): hold dec from count=5 → 4 at edge 7, 3 at edge 28, 2 at edge 37, 1 at edge 46. With REPEAT_EN=0, the same stimulus gives only 5→4.
- Limits:
  - WRAP=0, count=15, inc press → stays 15, at_max=1, no step. Count=0 with dec press → stays 0.
  - WRAP=1, count=15, inc press → 0, step=1, at_min=1.
- Conflicts: inc and dec pressed on the same edge → no change. dec pressed while inc is held in HOLD → ignored. dec accepted only after inc is released and the RELEASE filter expires.
- Reset mid-HOLD at count=9: rst asserted asynchronously → count=0, step=0, at_min=1 immediately. After rst deasserts, a clean inc press yields count=1 at the nominal latency.

Source files
------------

// File: rtl/button_counter_updown.sv
// Up/down push-button counter: 2-flop sync, shared debounce/repeat timer, wrap or saturate count.
// Latency: count moves DEBOUNCE_CYCLES+3 edges after the pin falls; free-running, no backpressure.
module button_counter_updown #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int WRAP            = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_btn,
    input  logic             dec_btn,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             step_dir,
    output logic             at_min,
    output logic             at_max
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CYC = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]    DEB_LD    = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]    DLY_LD    = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]    PER_LD    = TW'(REPEAT_PERIOD - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_STEP     = 3'd2,
        S_HOLD     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              dir_q, dir_d;
    logic              rep_q, rep_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              step_q, step_d;
    logic              step_dir_q, step_dir_d;
    logic              inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d;
    logic              dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d;

    logic              inc_p, dec_p, act_p, oth_p, tmr_zero;
    logic [TW-1:0]     tmr_dec;

    always_comb begin
        inc_s1_d = inc_btn;
        inc_s2_d = inc_s1_q;
        dec_s1_d = dec_btn;
        dec_s2_d = dec_s1_q;
    end

    always_comb begin
        inc_p    = ~inc_s2_q;
        dec_p    = ~dec_s2_q;
        act_p    = dir_q ? inc_p : dec_p;
        oth_p    = dir_q ? dec_p : inc_p;
        tmr_zero = (timer_q == '0);
        tmr_dec  = timer_q - TW'(1);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        rep_d      = rep_q;
        count_d    = count_q;
        step_d     = 1'b0;
        step_dir_d = step_dir_q;

        case (state_q)
            S_IDLE: begin
                if (inc_p ^ dec_p) begin
                    dir_d   = inc_p;
                    timer_d = DEB_LD;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!act_p || oth_p) begin
                    state_d = S_IDLE;
                end else if (tmr_zero) begin
                    rep_d   = 1'b0;
                    state_d = S_STEP;
                end else begin
                    timer_d = tmr_dec;
                end
            end
            S_STEP: begin
                timer_d = rep_q ? PER_LD : DLY_LD;
                state_d = S_HOLD;
                // At a saturation limit the FSM still walks through STEP, only the count is frozen.
                if (dir_q) begin
                    if ((count_q != COUNT_MAX) || (WRAP != 0)) begin
                        count_d    = count_q + WIDTH'(1);
                        step_d     = 1'b1;
                        step_dir_d = 1'b1;
                    end
                end else begin
                    if ((count_q != '0) || (WRAP != 0)) begin
                        count_d    = count_q - WIDTH'(1);
                        step_d     = 1'b1;
                        step_dir_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (!act_p) begin
                    timer_d = DEB_LD;
                    state_d = S_RELEASE;
                end else if ((REPEAT_EN != 0) && tmr_zero) begin
                    rep_d   = 1'b1;
                    state_d = S_STEP;
                end else if (!tmr_zero) begin
                    timer_d = tmr_dec;
                end
            end
            S_RELEASE: begin
                if (act_p) begin
                    timer_d = DEB_LD;
                end else if (tmr_zero) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = tmr_dec;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            dir_q      <= 1'b0;
            rep_q      <= 1'b0;
            count_q    <= '0;
            step_q     <= 1'b0;
            step_dir_q <= 1'b0;
            inc_s1_q   <= 1'b1;
            inc_s2_q   <= 1'b1;
            dec_s1_q   <= 1'b1;
            dec_s2_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            rep_q      <= rep_d;
            count_q    <= count_d;
            step_q     <= step_d;
            step_dir_q <= step_dir_d;
            inc_s1_q   <= inc_s1_d;
            inc_s2_q   <= inc_s2_d;
            dec_s1_q   <= dec_s1_d;
            dec_s2_q   <= dec_s2_d;
        end
    end

    assign count    = count_q;
    assign step     = step_q;
    assign step_dir = step_dir_q;
    assign at_min   = (count_q == '0);
    assign at_max   = (count_q == COUNT_MAX);

endmodule
